// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared encodings, FSM states and width defaults for the branch resolve unit
package branch_resolve_unit_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_e;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: EX-stage inputs and BTB/PC/flush/counter outputs of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             valid_EX;
    logic             stall_EX;
    logic             branch_EX;
    logic             jal_EX;
    logic             jalr_EX;
    logic [2:0]       funct3_EX;
    logic [XLEN-1:0]  rs1_EX;
    logic [XLEN-1:0]  rs2_EX;
    logic [XLEN-1:0]  imm_EX;
    logic [XLEN-1:0]  PC_EX;
    logic             pred_taken_EX;
    logic [XLEN-1:0]  pred_target_EX;
    logic             PC_enable;
    logic             takeBranch;
    logic             branch;
    logic             jumpAL;
    logic [XLEN-1:0]  branch_PC;
    logic             incorrect_b_prediction;
    logic             flush_IFID;
    logic             flush_IDEX;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output valid_EX, stall_EX, branch_EX, jal_EX, jalr_EX, funct3_EX,
               rs1_EX, rs2_EX, imm_EX, PC_EX, pred_taken_EX, pred_target_EX, PC_enable,
        input  takeBranch, branch, jumpAL, branch_PC, incorrect_b_prediction,
               flush_IFID, flush_IDEX, resolved_cnt, mispredict_cnt
    );

    modport slave (
        input  valid_EX, stall_EX, branch_EX, jal_EX, jalr_EX, funct3_EX,
               rs1_EX, rs2_EX, imm_EX, PC_EX, pred_taken_EX, pred_target_EX, PC_enable,
        output takeBranch, branch, jumpAL, branch_PC, incorrect_b_prediction,
               flush_IFID, flush_IDEX, resolved_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_branch_cond_cmp.sv
// branch_cond_cmp: combinational conditional-branch outcome from rs1, rs2 and funct3
module branch_cond_cmp
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic            o_taken
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = i_rs1 == i_rs2;
    assign w_lt  = $signed(i_rs1) < $signed(i_rs2);
    assign w_ltu = i_rs1 < i_rs2;

    always_comb begin
        o_taken = (i_funct3 == F3_BEQ)  ? w_eq   :
                  (i_funct3 == F3_BNE)  ? !w_eq  :
                  (i_funct3 == F3_BLT)  ? w_lt   :
                  (i_funct3 == F3_BGE)  ? !w_lt  :
                  (i_funct3 == F3_BLTU) ? w_ltu  :
                  (i_funct3 == F3_BGEU) ? !w_ltu : 1'b0;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution, mispredict redirect sequencing and accuracy counters
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_take;
    logic             r_branch;
    logic             r_jumpal;
    logic [XLEN-1:0]  r_branch_pc;
    logic [CNT_W-1:0] r_resolved;
    logic [CNT_W-1:0] r_mispred;
    logic             w_cond;
    logic             w_is_jump;
    logic             w_accept;
    logic             w_taken;
    logic             w_mispred;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;

    branch_cond_cmp #(.XLEN(XLEN)) u_cmp (
        .i_rs1   (bus.rs1_EX),
        .i_rs2   (bus.rs2_EX),
        .i_funct3(bus.funct3_EX),
        .o_taken (w_cond)
    );

    assign w_is_jump  = bus.jal_EX | bus.jalr_EX;
    assign w_accept   = bus.valid_EX & ~bus.stall_EX & (bus.branch_EX | w_is_jump) & (r_state == IDLE);
    assign w_taken    = w_is_jump | (bus.branch_EX & w_cond);
    assign w_jalr_sum = bus.rs1_EX + bus.imm_EX;
    assign w_target   = bus.jalr_EX ? {w_jalr_sum[XLEN-1:1], 1'b0} : bus.PC_EX + bus.imm_EX;
    assign w_next_pc  = w_taken ? w_target : bus.PC_EX + XLEN'(4);
    assign w_mispred  = (w_taken != bus.pred_taken_EX) | (w_taken & (bus.pred_target_EX != w_target));

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? ((w_accept & w_mispred) ? REDIRECT : IDLE)
                                        : (bus.PC_enable ? IDLE : REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_take      <= 1'b0;
            r_branch    <= 1'b0;
            r_jumpal    <= 1'b0;
            r_branch_pc <= '0;
            r_resolved  <= '0;
            r_mispred   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_branch <= w_accept & bus.branch_EX;
            r_jumpal <= w_accept & w_is_jump;
            if (w_accept) begin
                r_take      <= w_taken;
                r_branch_pc <= w_next_pc;
                r_resolved  <= r_resolved + CNT_W'(1);
            end
            if (w_accept & w_mispred)
                r_mispred <= r_mispred + CNT_W'(1);
        end
    end

    assign bus.takeBranch             = r_take;
    assign bus.branch                 = r_branch;
    assign bus.jumpAL                 = r_jumpal;
    assign bus.branch_PC              = r_branch_pc;
    assign bus.incorrect_b_prediction = r_state == REDIRECT;
    assign bus.flush_IFID             = r_state == REDIRECT;
    assign bus.flush_IDEX             = r_state == REDIRECT;
    assign bus.resolved_cnt           = r_resolved;
    assign bus.mispredict_cnt         = r_mispred;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table, corner sequences and randomized run against a reference model
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.CNT_W(32), .XLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, imm, pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        exp_take;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    bit          m_redirect, m_take, m_br, m_jal;
    logic [31:0] m_pc;
    int unsigned m_resolved, m_mispred;

    function automatic void ref_outcome(input logic br, jal, jalr, input logic [2:0] f3,
                                        input logic [31:0] a, b, imm, pc,
                                        output bit t, output logic [31:0] tgt, output logic [31:0] npc);
        longint sa, sb;
        logic [31:0] s;
        bit c;
        sa = a[31] ? longint'(a) - 64'h1_0000_0000 : longint'(a);
        sb = b[31] ? longint'(b) - 64'h1_0000_0000 : longint'(b);
        case (f3)
            3'd0: c = a == b;
            3'd1: c = a != b;
            3'd4: c = sa < sb;
            3'd5: c = sa >= sb;
            3'd6: c = a < b;
            3'd7: c = a >= b;
            default: c = 1'b0;
        endcase
        t = (jal | jalr) ? 1'b1 : (br & c);
        s = a + imm;
        tgt = jalr ? (s & 32'hFFFF_FFFE) : pc + imm;
        npc = t ? tgt : pc + 32'd4;
    endfunction

    task automatic model_step();
        bit t, acc;
        logic [31:0] tgt, npc;
        if (!rst_n) begin
            m_redirect = 0; m_take = 0; m_br = 0; m_jal = 0; m_pc = 0; m_resolved = 0; m_mispred = 0;
        end else if (m_redirect) begin
            m_br = 0; m_jal = 0;
            if (bus.PC_enable) m_redirect = 0;
        end else begin
            acc = bus.valid_EX & ~bus.stall_EX & (bus.branch_EX | bus.jal_EX | bus.jalr_EX);
            m_br = acc & bus.branch_EX;
            m_jal = acc & (bus.jal_EX | bus.jalr_EX);
            if (acc) begin
                ref_outcome(bus.branch_EX, bus.jal_EX, bus.jalr_EX, bus.funct3_EX, bus.rs1_EX, bus.rs2_EX,
                            bus.imm_EX, bus.PC_EX, t, tgt, npc);
                m_take = t; m_pc = npc; m_resolved++;
                if (t != bus.pred_taken_EX || (t && tgt != bus.pred_target_EX)) begin
                    m_mispred++; m_redirect = 1;
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_take"}, bus.takeBranch, m_take);
        check({tag, "_branch"}, bus.branch, m_br);
        check({tag, "_jumpAL"}, bus.jumpAL, m_jal);
        check({tag, "_branch_PC"}, bus.branch_PC, m_pc);
        check({tag, "_incorrect"}, bus.incorrect_b_prediction, m_redirect);
        check({tag, "_flush_IFID"}, bus.flush_IFID, m_redirect);
        check({tag, "_flush_IDEX"}, bus.flush_IDEX, m_redirect);
        check({tag, "_resolved"}, bus.resolved_cnt, m_resolved);
        check({tag, "_mispred"}, bus.mispredict_cnt, m_mispred);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic valid, stall, br, jal, jalr, input logic [2:0] f3,
                         input logic [31:0] rs1, rs2, imm, pc, input logic pt, input logic [31:0] ptgt,
                         input logic pen);
        bus.valid_EX = valid; bus.stall_EX = stall; bus.branch_EX = br; bus.jal_EX = jal; bus.jalr_EX = jalr;
        bus.funct3_EX = f3; bus.rs1_EX = rs1; bus.rs2_EX = rs2; bus.imm_EX = imm; bus.PC_EX = pc;
        bus.pred_taken_EX = pt; bus.pred_target_EX = ptgt; bus.PC_enable = pen;
    endtask

    task automatic idle(input logic pen);
        drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, pen);
    endtask

    function automatic vec_t mkv(input logic br, jal, jalr, input logic [2:0] f3,
                                 input logic [31:0] rs1, rs2, imm, pc, input logic pt,
                                 input logic [31:0] ptgt, input logic et, input logic [31:0] epc,
                                 input logic em);
        vec_t v;
        v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.pc = pc; v.pt = pt; v.ptgt = ptgt; v.exp_take = et; v.exp_pc = epc; v.exp_mis = em;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        int unsigned saved;
        vecs[0]  = mkv(1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1, 32'h120, 1, 32'h120, 0);
        vecs[1]  = mkv(1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h0, 1, 32'h240, 1);
        vecs[2]  = mkv(1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h0, 0, 32'h204, 0);
        vecs[3]  = mkv(0, 0, 1, 3'd0, 32'h1003, 32'd0, 32'h0, 32'h50, 1, 32'h1000, 1, 32'h1002, 1);
        vecs[4]  = mkv(1, 0, 0, 3'd1, 32'd7, 32'd7, 32'h8, 32'h300, 1, 32'h308, 0, 32'h304, 1);
        vecs[5]  = mkv(1, 0, 0, 3'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFF0, 32'h400, 1, 32'h3F0, 1, 32'h3F0, 0);
        vecs[6]  = mkv(1, 0, 0, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h500, 0, 32'h0, 0, 32'h504, 0);
        vecs[7]  = mkv(1, 0, 0, 3'd2, 32'd9, 32'd9, 32'h10, 32'h600, 0, 32'h0, 0, 32'h604, 0);
        vecs[8]  = mkv(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 1, 32'h10, 1, 32'h10, 0);
        vecs[9]  = mkv(1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h10, 32'h700, 1, 32'h714, 1, 32'h710, 1);
        vecs[10] = mkv(0, 0, 1, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'h2, 32'h80, 0, 32'h0, 1, 32'h0, 1);

        idle(1);
        rst_n = 0;
        step("reset");
        step("reset2");
        check("reset_incorrect", bus.incorrect_b_prediction, 0);
        check("reset_resolved", bus.resolved_cnt, 0);
        rst_n = 1;

        foreach (vecs[i]) begin
            drive(1, 0, vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].pc, vecs[i].pt, vecs[i].ptgt, 1);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d_exp_take", i), bus.takeBranch, vecs[i].exp_take);
            check($sformatf("vec%0d_exp_pc", i), bus.branch_PC, vecs[i].exp_pc);
            check($sformatf("vec%0d_exp_mis", i), bus.incorrect_b_prediction, vecs[i].exp_mis);
            check($sformatf("vec%0d_exp_br", i), bus.branch, vecs[i].br);
            check($sformatf("vec%0d_exp_jal", i), bus.jumpAL, vecs[i].jal | vecs[i].jalr);
            idle(1);
            step($sformatf("vec%0d_idle", i));
        end

        drive(1, 0, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h0, 0);
        step("hold_accept");
        saved = m_resolved;
        drive(1, 0, 1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h10, 32'h900, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_incorrect", k), bus.incorrect_b_prediction, 1);
            check($sformatf("hold%0d_pc", k), bus.branch_PC, 32'h240);
            check($sformatf("hold%0d_resolved", k), bus.resolved_cnt, saved);
            if (k < 2) step($sformatf("hold%0d", k));
        end
        bus.PC_enable = 1;
        step("hold_release");
        check("hold_release_incorrect", bus.incorrect_b_prediction, 0);
        check("hold_release_resolved", bus.resolved_cnt, saved);
        check("hold_release_branch", bus.branch, 0);

        saved = m_resolved;
        drive(1, 1, 1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h30, 32'hA00, 1, 32'hA30, 1);
        step("stall0");
        step("stall1");
        check("stall_resolved", bus.resolved_cnt, saved);
        check("stall_branch", bus.branch, 0);
        bus.stall_EX = 0;
        step("unstall");
        check("unstall_branch", bus.branch, 1);
        check("unstall_resolved", bus.resolved_cnt, saved + 1);
        idle(1);
        step("unstall_after");
        check("unstall_after_branch", bus.branch, 0);

        drive(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'hB00, 0, 32'h0, 0);
        step("rst_redirect");
        check("rst_redirect_on", bus.incorrect_b_prediction, 1);
        rst_n = 0;
        step("rst_mid");
        check("rst_mid_incorrect", bus.incorrect_b_prediction, 0);
        check("rst_mid_flush", bus.flush_IDEX, 0);
        check("rst_mid_pc", bus.branch_PC, 0);
        check("rst_mid_mispred", bus.mispredict_cnt, 0);
        rst_n = 1;
        drive(1, 0, 1, 0, 0, 3'd1, 32'd4, 32'd4, 32'h40, 32'h800, 0, 32'h0, 1);
        step("post_rst_bne");
        check("post_rst_take", bus.takeBranch, 0);
        check("post_rst_pc", bus.branch_PC, 32'h804);
        check("post_rst_resolved", bus.resolved_cnt, 1);

        for (int n = 0; n < 3000; n++) begin
            int kind;
            bit t;
            logic [31:0] a, b, imm, pc, tgt, npc;
            logic [2:0] f3;
            kind = $urandom_range(0, 3);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            pc = $urandom;
            ref_outcome(kind == 1, kind == 2, kind == 3, f3, a, b, imm, pc, t, tgt, npc);
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, kind == 1, kind == 2, kind == 3, f3,
                  a, b, imm, pc, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? tgt : tgt ^ 32'h4, $urandom_range(0, 1) == 1);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
